window_dot_seq: RTL and testbench
=================================

// Module: window_dot_seq
// PURPOSE
//  Downstream consumer of the 19-tap byte shift window. On start, snapshots the
//  parallel window and a parallel weight vector, then computes a signed dot product
//  sequentially, LANES taps per cycle. Adds bias, scales, applies optional ReLU and
//  saturates. Presents the result on a valid/ready port.
//  busy_o lets the sequencer keep shifting the window (wen) while a MAC is in flight.
// PARAMETERS
//  TAPS   19  number of window taps; byte i of win_i = tap i, tap 0 = oldest
//  LANES  1   taps multiplied/accumulated per cycle (1..TAPS; need not divide TAPS)
//  ACC_W  24  signed accumulator width (>= 16+clog2(TAPS)+1)
//  SHIFT  0   arithmetic right shift applied to acc before saturation
//  OUT_W  8   signed result width
//  RELU   1   1: negative scaled result forced to 0
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            asynchronous reset, active-low
//  win_i        in   TAPS*8       window bytes, signed int8, tap i at [i*8+:8]
//  wgt_i        in   TAPS*8       weights, signed int8, same packing
//  bias_i       in   ACC_W        signed bias, accumulator preload
//  start_i      in   1            request; accepted per rule below
//  busy_o       out  1            state != IDLE
//  res_valid_o  out  1            result available (state DONE)
//  res_ready_i  in   1            consumer accepts result
//  res_o        out  OUT_W        scaled/ReLU/saturated result
//  acc_o        out  ACC_W        raw accumulator (bias + sum of products)
// BEHAVIOUR
//  - Reset: state IDLE, acc=0, idx=0, snapshots=0; busy_o=0, res_valid_o=0, res_o=0, acc_o=0.
//  - accept = start_i & (IDLE | (DONE & res_ready_i)). On accept: latch win_i, wgt_i
//    into snapshot regs, acc<=bias_i, idx<=0, state<=RUN. Inputs may change afterwards.
//  - start_i is ignored in RUN, and in DONE without res_ready_i (no queueing).
//  - RUN: acc += sum over k<LANES of snap_win[idx+k]*snap_wgt[idx+k]. Products are signed
//    8x8 -> 16 and sign-extended to ACC_W. Lanes with idx+k >= TAPS contribute 0. idx += LANES.
//    On the beat where idx+LANES >= TAPS: state<=DONE.
//  - Latency: accept edge to res_valid_o high = ceil(TAPS/LANES) cycles (19 for LANES=1).
//  - DONE: res_valid_o=1. acc_o and res_o are held stable until handshake (valid & ready).
//    On handshake: -> IDLE, or -> RUN if accept in the same cycle (back-to-back, zero bubble).
//  - res_o = sat_OUT_W( RELU && s<0 ? 0 : s ), s = acc >>> SHIFT. Saturation limits are
//    [-2^(OUT_W-1), 2^(OUT_W-1)-1]. res_o is combinational from the acc register only.
//  - acc_o/res_o are driven from the internal acc in all states. They are valid only while
//    res_valid_o is high.
//  - Accumulation wraps modulo 2^ACC_W; defaults cannot overflow
//    (max |sum| = 19*16384 = 311296 plus bias).
//  - Async reset mid-RUN/DONE: immediate return to reset values; in-flight result is discarded.
// STRUCTURE
//  - Package win_pkg: TAPS, DATA_W=8, PROD_W=16, ACC_W default, state enum {IDLE,RUN,DONE}.
//    Shared with the window shift RAM and its sequencer.
//  - Sub-module mac_lanes: combinational LANES-wide signed product sum with tap masking.
//    Top holds the FSM, idx counter, snapshot regs, acc and the output scaling/saturation.
// TESTING
//  1 win=all 1, wgt=all 1, bias=0, LANES=1 -> res_valid after 19 cycles, acc_o=19, res_o=19.
//  2 win=all -128, wgt=all -128, bias=0 -> acc_o=311296, res_o=127 (sat). With
//    bias=-311300: acc_o=-4, RELU=1 -> res_o=0; RELU=0 -> res_o=-4.
//  3 win=i+1, wgt=1, SHIFT=2, bias=3 -> acc_o=193, res_o=48. LANES=4 -> done in 5 cycles,
//    same values.
//  4 res_ready low 6 cycles in DONE with start_i pulsing, win_i changing ->
//    acc_o/res_o/valid stable, no new op.
//  5 start_i and res_ready_i high together in DONE -> result consumed, new op starts, no IDLE
//    cycle. Changing win_i during RUN does not alter the result.
//  6 rst_n low at cycle 10 of RUN -> all outputs 0 next; subsequent start gives the correct
//    fresh result.

Source files
------------

// File: rtl/win_pkg.sv
// Shared definitions for the byte shift window, its sequencer and the
// window dot-product engine.
package win_pkg;

   localparam int TAPS   = 19;
   localparam int DATA_W = 8;
   localparam int PROD_W = 16;
   localparam int ACC_W  = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/window_dot_seq_mac_lanes.sv
// Combinational LANES-wide signed multiply/sum over the snapshot window,
// starting at tap idx; taps past the end of the window contribute zero.
module mac_lanes
   import win_pkg::*;
#(
   parameter int TAPS  = win_pkg::TAPS,
   parameter int LANES = 1,
   parameter int ACC_W = win_pkg::ACC_W,
   parameter int IDX_W = 5
) (
   input  logic [TAPS*DATA_W-1:0]  win,
   input  logic [TAPS*DATA_W-1:0]  wgt,
   input  logic [IDX_W-1:0]        idx,
   output logic signed [ACC_W-1:0] sum
);

   // Sum of the sign-extended products of the lanes that still fall inside the window
   always_comb begin
      sum = '0;
      for (int k = 0; k < LANES; k++) begin
         int tap;
         int sel;
         logic signed [PROD_W-1:0] prod;
         tap  = int'(idx) + k;
         sel  = (tap < TAPS) ? tap : 0;
         prod = $signed(win[sel*DATA_W +: DATA_W]) * $signed(wgt[sel*DATA_W +: DATA_W]);
         sum  = sum + ((tap < TAPS) ? {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : '0);
      end
   end

endmodule

// File: rtl/window_dot_seq.sv
// Sequential signed dot product of a snapshot of the tap window against a weight
// vector, with bias preload, arithmetic scaling, optional ReLU and saturation.
module window_dot_seq
   import win_pkg::*;
#(
   parameter int TAPS  = win_pkg::TAPS,
   parameter int LANES = 1,
   parameter int ACC_W = win_pkg::ACC_W,
   parameter int SHIFT = 0,
   parameter int OUT_W = 8,
   parameter bit RELU  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [TAPS*DATA_W-1:0]  win_i,
   input  logic [TAPS*DATA_W-1:0]  wgt_i,
   input  logic signed [ACC_W-1:0] bias_i,
   input  logic                    start_i,
   output logic                    busy_o,
   output logic                    res_valid_o,
   input  logic                    res_ready_i,
   output logic signed [OUT_W-1:0] res_o,
   output logic signed [ACC_W-1:0] acc_o
);

   localparam int IDX_W = $clog2(TAPS + LANES + 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [IDX_W-1:0]        idx_r;
   logic signed [ACC_W-1:0] acc_r;
   logic signed [ACC_W-1:0] sum_s;
   logic [TAPS*DATA_W-1:0]  snap_win_r;
   logic [TAPS*DATA_W-1:0]  snap_wgt_r;
   logic                    accept_s;
   logic                    last_beat_s;

   function automatic logic signed [OUT_W-1:0] scale_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      s = a >>> SHIFT;
      if (RELU && s[ACC_W-1]) begin
         s = '0;
      end else begin
         s = s;
      end
      if (s > SAT_MAX) begin
         s = SAT_MAX;
      end else if (s < SAT_MIN) begin
         s = SAT_MIN;
      end else begin
         s = s;
      end
      return s[OUT_W-1:0];
   endfunction

   // A new request may only enter while idle or while the pending result is being taken
   assign accept_s    = start_i && ((state_r == IDLE) || ((state_r == DONE) && res_ready_i));
   assign last_beat_s = (int'(idx_r) + LANES) >= TAPS;

   mac_lanes #(
      .TAPS  (TAPS),
      .LANES (LANES),
      .ACC_W (ACC_W),
      .IDX_W (IDX_W)
   ) u_mac_lanes (
      .win (snap_win_r),
      .wgt (snap_wgt_r),
      .idx (idx_r),
      .sum (sum_s)
   );

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = RUN;
            else          state_nxt_s = IDLE;
         end
         RUN: begin
            if (last_beat_s) state_nxt_s = DONE;
            else             state_nxt_s = RUN;
         end
         DONE: begin
            if (accept_s)         state_nxt_s = RUN;
            else if (res_ready_i) state_nxt_s = IDLE;
            else                  state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // Snapshot capture and accumulation; acc is only touched on accept or in RUN,
   // so it holds steady through DONE until the result is consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_win_r <= '0;
         snap_wgt_r <= '0;
         acc_r      <= '0;
         idx_r      <= '0;
      end else if (accept_s) begin
         snap_win_r <= win_i;
         snap_wgt_r <= wgt_i;
         acc_r      <= bias_i;
         idx_r      <= '0;
      end else if (state_r == RUN) begin
         acc_r      <= acc_r + sum_s;
         idx_r      <= idx_r + IDX_W'(LANES);
      end
   end

   assign busy_o      = (state_r != IDLE);
   assign res_valid_o = (state_r == DONE);
   assign acc_o       = acc_r;
   assign res_o       = scale_sat(acc_r);

endmodule

// File: tb/tb_window_dot_seq.sv
// Scoreboard bench: two engines (LANES=1/SHIFT=0/RELU=1 and LANES=4/SHIFT=2/RELU=0)
// share stimulus; expected results come from a plain-arithmetic dot-product model.
module tb_window_dot_seq;
   import win_pkg::*;

   localparam int W     = TAPS * DATA_W;
   localparam int LAT_A = (TAPS + 1 - 1) / 1;
   localparam int LAT_B = (TAPS + 4 - 1) / 4;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [W-1:0]            win_i;
   logic [W-1:0]            wgt_i;
   logic signed [ACC_W-1:0] bias_i;
   logic                    start_i;
   logic                    res_ready_i;
   logic                    busy_a, valid_a, busy_b, valid_b;
   logic signed [7:0]       res_a, res_b;
   logic signed [ACC_W-1:0] acc_a, acc_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic signed [ACC_W-1:0] acc;
      logic signed [7:0]       res;
      int                      t0;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   bit   seen_a;
   bit   seen_b;

   window_dot_seq #(.LANES(1), .SHIFT(0), .RELU(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .win_i(win_i), .wgt_i(wgt_i), .bias_i(bias_i),
      .start_i(start_i), .busy_o(busy_a), .res_valid_o(valid_a),
      .res_ready_i(res_ready_i), .res_o(res_a), .acc_o(acc_a)
   );

   window_dot_seq #(.LANES(4), .SHIFT(2), .RELU(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .win_i(win_i), .wgt_i(wgt_i), .bias_i(bias_i),
      .start_i(start_i), .busy_o(busy_b), .res_valid_o(valid_b),
      .res_ready_i(res_ready_i), .res_o(res_b), .acc_o(acc_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: dot product in wide integers, wrap to ACC_W, then shift/ReLU/clamp
   function automatic exp_t model(input logic [W-1:0] w, input logic [W-1:0] g,
                                  input logic signed [ACC_W-1:0] b,
                                  input int shift, input bit relu);
      exp_t   e;
      longint sum;
      longint s;
      sum = longint'(b);
      for (int t = 0; t < TAPS; t++) begin
         sum += longint'($signed(w[t*8 +: 8])) * longint'($signed(g[t*8 +: 8]));
      end
      e.acc = sum[ACC_W-1:0];
      s = longint'(e.acc) >>> shift;
      if (relu && s < 0) s = 0;
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      e.res = s[7:0];
      e.t0  = 0;
      return e;
   endfunction

   function automatic logic [W-1:0] fill(input logic [7:0] v);
      logic [W-1:0] r;
      for (int t = 0; t < TAPS; t++) r[t*8 +: 8] = v;
      return r;
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] r;
      for (int t = 0; t < TAPS; t++) r[t*8 +: 8] = 8'($urandom);
      return r;
   endfunction

   function automatic logic signed [ACC_W-1:0] rand_bias();
      if ($urandom_range(0, 3) == 0) return ACC_W'($urandom);
      return ACC_W'(int'($urandom_range(0, 200000)) - 100000);
   endfunction

   // Monitor for engine A: compare every cycle the result is presented, pop on handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         qa.delete();
         seen_a = 1'b0;
      end else if (valid_a) begin
         if (qa.size() == 0) begin
            check("a_unexpected_valid", 1, 0);
         end else begin
            if (!seen_a) begin
               check("a_latency", cyc - qa[0].t0, LAT_A);
               seen_a = 1'b1;
            end
            check("a_acc", acc_a, qa[0].acc);
            check("a_res", res_a, qa[0].res);
            if (res_ready_i) begin
               void'(qa.pop_front());
               seen_a = 1'b0;
            end
         end
      end
   end

   // Monitor for engine B
   always @(negedge clk) begin
      if (!rst_n) begin
         qb.delete();
         seen_b = 1'b0;
      end else if (valid_b) begin
         if (qb.size() == 0) begin
            check("b_unexpected_valid", 1, 0);
         end else begin
            if (!seen_b) begin
               check("b_latency", cyc - qb[0].t0, LAT_B);
               seen_b = 1'b1;
            end
            check("b_acc", acc_b, qb[0].acc);
            check("b_res", res_b, qb[0].res);
            if (res_ready_i) begin
               void'(qb.pop_front());
               seen_b = 1'b0;
            end
         end
      end
   end

   // Issue a request when A is idle, or together with the handshake if A holds a result
   task automatic issue(input logic [W-1:0] w, input logic [W-1:0] g,
                        input logic signed [ACC_W-1:0] b);
      exp_t ea;
      exp_t eb;
      int   n;
      n = 0;
      while (busy_a && !valid_a && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check("issue_wait_timeout", n, 0);
      win_i       = w;
      wgt_i       = g;
      bias_i      = b;
      start_i     = 1'b1;
      res_ready_i = valid_a;
      ea    = model(w, g, b, 0, 1'b1);
      eb    = model(w, g, b, 2, 1'b0);
      ea.t0 = cyc + 1;
      eb.t0 = cyc + 1;
      qa.push_back(ea);
      qb.push_back(eb);
      @(posedge clk); #1;
      start_i     = 1'b0;
      res_ready_i = 1'b0;
      check("a_busy_after_accept", busy_a, 1);
      check("a_valid_after_accept", valid_a, 0);
      check("b_busy_after_accept", busy_b, 1);
   endtask

   // Wait for A's result; optionally disturb inputs and pulse start meanwhile
   task automatic wait_done(input bit scramble);
      int n;
      n = 0;
      while (!valid_a && n < 100) begin
         if (scramble) begin
            win_i   = rand_vec();
            wgt_i   = rand_vec();
            bias_i  = rand_bias();
            start_i = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         n++;
      end
      start_i = 1'b0;
      if (n >= 100) check("done_wait_timeout", n, 0);
   endtask

   task automatic stall(input int cycles);
      res_ready_i = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         win_i   = rand_vec();
         start_i = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      start_i = 1'b0;
   endtask

   task automatic drain();
      start_i     = 1'b0;
      res_ready_i = 1'b1;
      @(posedge clk); #1;
      res_ready_i = 1'b0;
      check("a_idle_after_drain", busy_a, 0);
      check("b_idle_after_drain", busy_b, 0);
   endtask

   initial begin
      logic [W-1:0] ramp;
      rst_n       = 1'b0;
      win_i       = '0;
      wgt_i       = '0;
      bias_i      = '0;
      start_i     = 1'b0;
      res_ready_i = 1'b0;
      for (int t = 0; t < TAPS; t++) ramp[t*8 +: 8] = 8'(t + 1);

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy_a", busy_a, 0);
      check("rst_valid_a", valid_a, 0);
      check("rst_res_a", res_a, 0);
      check("rst_acc_a", acc_a, 0);
      check("rst_busy_b", busy_b, 0);
      check("rst_acc_b", acc_b, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed: all ones, saturation, ReLU vs signed result, ramp with bias
      issue(fill(8'd1), fill(8'd1), 24'sd0);             wait_done(1'b0); drain();
      issue(fill(8'h80), fill(8'h80), 24'sd0);           wait_done(1'b0); drain();
      issue(fill(8'h80), fill(8'h80), -24'sd311300);     wait_done(1'b0); drain();
      issue(ramp, fill(8'd1), 24'sd3);                   wait_done(1'b0); drain();

      // Held result under stall with start pulsing, then back-to-back with input churn
      issue(rand_vec(), rand_vec(), rand_bias());
      wait_done(1'b1);
      stall(6);
      issue(rand_vec(), rand_vec(), rand_bias());
      wait_done(1'b1);
      drain();

      // Reset in the middle of a run, then a fresh operation
      issue(fill(8'd5), fill(8'd7), 24'sd11);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy_a", busy_a, 0);
      check("mid_rst_valid_a", valid_a, 0);
      check("mid_rst_res_a", res_a, 0);
      check("mid_rst_acc_a", acc_a, 0);
      check("mid_rst_busy_b", busy_b, 0);
      check("mid_rst_valid_b", valid_b, 0);
      check("mid_rst_res_b", res_b, 0);
      check("mid_rst_acc_b", acc_b, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(ramp, fill(8'd1), 24'sd3); wait_done(1'b1); drain();

      // Randomized traffic mixing stalls, drains and back-to-back requests
      for (int i = 0; i < 25; i++) begin
         issue(rand_vec(), rand_vec(), rand_bias());
         wait_done(1'b1);
         stall(int'($urandom_range(0, 4)));
         if ($urandom_range(0, 1) == 1) drain();
      end
      if (valid_a) drain();

      repeat (3) @(posedge clk);
      #1;
      check("a_queue_empty", qa.size(), 0);
      check("b_queue_empty", qb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
